// File: rtl/fp_normalize_round.sv
// Post-normalization and round-to-nearest-even stage for the add/sub datapath.
// The incoming {carry, hidden, fraction, guard} mantissa is renormalized one
// bit per clock (each shift adjusts the exponent), rounded, then packed into
// sign/exponent/fraction with inexact/overflow/underflow flags.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE and outside reset. out_valid is
// high only in DONE, and the outputs hold steady until out_ready is seen.
module fp_normalize_round #(
  parameter int EXP_SIZE    = 8,
  parameter int MANTIS_SIZE = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_SIZE-1:0]      in_exp,
  input  logic [MANTIS_SIZE+2:0]   in_mantis,
  input  logic                     in_sticky,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic [EXP_SIZE-1:0]      out_exp,
  output logic [MANTIS_SIZE-1:0]   out_frac,
  output logic                     out_inexact,
  output logic                     out_overflow,
  output logic                     out_underflow,
  output logic [1:0]               dbg_state
);

  localparam int MW = MANTIS_SIZE + 3;  // {carry, hidden, fraction, guard}
  localparam int EW = EXP_SIZE + 1;     // extra MSB catches exponent overflow

  localparam logic [EW-1:0] EXP_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] EXP_ONES = {1'b0, {EXP_SIZE{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic            sign_q, sign_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic [MW-1:0]   man_q, man_d;
  logic            sticky_q, sticky_d;

  // Result values presented to the output registers when out_load is set
  logic                   out_load;
  logic                   res_sign;
  logic [EXP_SIZE-1:0]    res_exp;
  logic [MANTIS_SIZE-1:0] res_frac;
  logic                   res_inexact;
  logic                   res_overflow;
  logic                   res_underflow;

  // Rounding datapath, evaluated from the normalized working registers
  logic [MANTIS_SIZE:0]   sig;
  logic [MANTIS_SIZE+1:0] sig_sum;
  logic                   rnd_inc;
  logic [EW-1:0]          rnd_exp;
  logic [MANTIS_SIZE-1:0] rnd_frac;
  logic                   rnd_ovf;
  logic                   rnd_inexact;
  logic                   rnd_unf;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign dbg_state = state_q;

  // Round-to-nearest-even on {hidden, fraction}, then clamp to infinity
  always_comb begin
    sig         = man_q[MW-2:1];
    rnd_inc     = man_q[0] & (sticky_q | man_q[1]);
    sig_sum     = {1'b0, sig} + {{(MANTIS_SIZE+1){1'b0}}, rnd_inc};
    rnd_exp     = exp_q;
    rnd_frac    = sig_sum[MANTIS_SIZE-1:0];
    rnd_ovf     = 1'b0;
    if (sig_sum[MANTIS_SIZE+1]) begin
      // Significand wrapped to 10.000...: fraction becomes zero, exponent bumps
      rnd_frac = '0;
      rnd_exp  = exp_q + EXP_ONE;
    end else if ((exp_q == '0) && sig_sum[MANTIS_SIZE] && !man_q[MW-2]) begin
      // A denormal that rounds up into the hidden bit becomes the smallest normal
      rnd_exp = EXP_ONE;
    end
    if (rnd_exp >= EXP_ONES) begin
      rnd_exp  = EXP_ONES;
      rnd_frac = '0;
      rnd_ovf  = 1'b1;
    end
    rnd_inexact = man_q[0] | sticky_q;
    rnd_unf     = rnd_inexact && (rnd_exp == '0);
  end

  // Next-state and working-register updates; one normalization action per cycle
  always_comb begin
    state_d       = state_q;
    sign_d        = sign_q;
    exp_d         = exp_q;
    man_d         = man_q;
    sticky_d      = sticky_q;
    out_load      = 1'b0;
    res_sign      = 1'b0;
    res_exp       = '0;
    res_frac      = '0;
    res_inexact   = 1'b0;
    res_overflow  = 1'b0;
    res_underflow = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = in_sign;
          exp_d    = {1'b0, in_exp};
          man_d    = in_mantis;
          sticky_d = in_sticky;
          if (&in_exp) begin
            // Inf/NaN passes straight through with its payload and no flags
            out_load = 1'b1;
            res_sign = in_sign;
            res_exp  = {EXP_SIZE{1'b1}};
            res_frac = in_mantis[MW-3:1];
            state_d  = DONE;
          end else begin
            state_d  = NORM;
          end
        end
      end
      NORM: begin
        if ((man_q == '0) && !sticky_q) begin
          exp_d   = '0;
          state_d = ROUND;
        end else if (man_q[MW-1]) begin
          man_d    = {1'b0, man_q[MW-1:1]};
          sticky_d = sticky_q | man_q[0];
          exp_d    = exp_q + EXP_ONE;
          state_d  = ROUND;
        end else if (!man_q[MW-2] && (exp_q > EXP_ONE)) begin
          man_d = {man_q[MW-2:0], 1'b0};
          exp_d = exp_q - EXP_ONE;
        end else if (!man_q[MW-2]) begin
          exp_d   = '0;
          state_d = ROUND;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        out_load      = 1'b1;
        res_sign      = sign_q;
        res_exp       = rnd_exp[EXP_SIZE-1:0];
        res_frac      = rnd_frac;
        res_inexact   = rnd_inexact;
        res_overflow  = rnd_ovf;
        res_underflow = rnd_unf;
        exp_d         = rnd_exp;
        state_d       = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      man_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      man_q    <= man_d;
      sticky_q <= sticky_d;
    end
  end

  // Output registers, loaded only on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sign      <= 1'b0;
      out_exp       <= '0;
      out_frac      <= '0;
      out_inexact   <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else if (out_load) begin
      out_sign      <= res_sign;
      out_exp       <= res_exp;
      out_frac      <= res_frac;
      out_inexact   <= res_inexact;
      out_overflow  <= res_overflow;
      out_underflow <= res_underflow;
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round (EXP_SIZE=8, MANTIS_SIZE=23): directed cases
// followed by randomized operands, each checked against an arithmetic model.
module tb_fp_normalize_round;

  localparam int E  = 8;
  localparam int MS = 23;
  localparam int MW = MS + 3;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [E-1:0]  in_exp = '0;
  logic [MW-1:0] in_mantis = '0;
  logic          in_sticky = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sign;
  logic [E-1:0]  out_exp;
  logic [MS-1:0] out_frac;
  logic          out_inexact;
  logic          out_overflow;
  logic          out_underflow;
  logic [1:0]    dbg_state;

  fp_normalize_round #(.EXP_SIZE(E), .MANTIS_SIZE(MS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mantis(in_mantis), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
    .out_inexact(out_inexact), .out_overflow(out_overflow), .out_underflow(out_underflow),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: value-level normalization (leading-zero count clamped by
  // the exponent floor) followed by integer round-half-to-even.
  task automatic model(input logic [E-1:0] ie, input logic [MW-1:0] im, input logic is,
                       output logic [E-1:0] oe, output logic [MS-1:0] of,
                       output logic ox, output logic ov, output logic ou, output int lat);
    int     e;
    longint m;
    longint q;
    logic   s;
    logic   g;
    int     k;
    int     need;
    int     p;
    e = ie; m = im; s = is; k = 0; ov = 1'b0;
    if (ie == 8'hFF) begin
      oe = 8'hFF; of = im[MS:1]; ox = 1'b0; ou = 1'b0; lat = 1;
      return;
    end
    if (m == 0 && !s) begin
      e = 0;
    end else if (m >= (64'd1 << 25)) begin
      s = s | ((m & 64'd1) != 0);
      m = m / 2;
      e = e + 1;
    end else if (m < (64'd1 << 24)) begin
      if (m == 0) need = 1000;
      else begin
        p = 0;
        for (int i = 0; i < 26; i++) if (((m >> i) & 64'd1) != 0) p = i;
        need = 24 - p;
      end
      if (e - 1 >= need) begin
        k = need; e = e - need; m = m << need;
      end else begin
        k = (e > 1) ? e - 1 : 0; m = m << k; e = 0;
      end
    end
    g = ((m & 64'd1) != 0);
    q = m / 2;
    if (g && (s || (q % 2 == 1))) begin
      if (q + 1 == (64'd1 << 24)) e = e + 1;
      else if (e == 0 && q < (64'd1 << 23) && q + 1 >= (64'd1 << 23)) e = 1;
      q = q + 1;
    end
    of = MS'(q % (64'd1 << 23));
    if (e >= 255) begin
      e = 255; of = '0; ov = 1'b1;
    end
    ox  = g | s;
    ou  = ox && (e == 0);
    oe  = E'(e);
    lat = k + 2;
  endtask

  // Driver: one operand through the DUT, checked for latency, value, flags and
  // stability under `hold` cycles of backpressure before it is released.
  task automatic run_op(input string tag, input logic sg, input logic [E-1:0] ie,
                        input logic [MW-1:0] im, input logic is, input int hold);
    logic [E-1:0]  x_exp;
    logic [MS-1:0] x_frac;
    logic          x_inx, x_ovf, x_unf;
    int            x_lat;
    int            n;
    logic          got;
    model(ie, im, is, x_exp, x_frac, x_inx, x_ovf, x_unf, x_lat);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_sign = sg; in_exp = ie; in_mantis = im; in_sticky = is;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sign = $urandom; in_exp = E'($urandom);
    in_mantis = MW'($urandom); in_sticky = $urandom;
    n = 0; got = 1'b0;
    while (n < 400 && !got) begin
      @(posedge clk); n++;
      #1;
      if (out_valid) got = 1'b1;
    end
    chk({tag, "_valid"}, got, 1);
    if (got) begin
      chk({tag, "_latency"}, n, x_lat);
      chk({tag, "_sign"}, out_sign, sg);
      chk({tag, "_exp"}, out_exp, x_exp);
      chk({tag, "_frac"}, out_frac, x_frac);
      chk({tag, "_inexact"}, out_inexact, x_inx);
      chk({tag, "_overflow"}, out_overflow, x_ovf);
      chk({tag, "_underflow"}, out_underflow, x_unf);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_in_ready"}, in_ready, 0);
        chk({tag, "_hold_result"}, {out_sign, out_exp, out_frac}, {sg, x_exp, x_frac});
        chk({tag, "_hold_flags"}, {out_inexact, out_overflow, out_underflow},
            {x_inx, x_ovf, x_unf});
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_released"}, out_valid, 0);
    end else begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic          sg, st;
    logic [E-1:0]  ex;
    logic [MW-1:0] mt;
    int            cls, er;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_result", {out_sign, out_exp, out_frac}, 0);
    chk("reset_flags", {out_inexact, out_overflow, out_underflow}, 0);
    chk("reset_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);

    // Directed cases
    run_op("plain",       1'b0, 8'h80, 26'h1000000, 1'b0, 0);
    run_op("right_shift", 1'b1, 8'h7F, 26'h2000001, 1'b0, 0);
    run_op("left3",       1'b0, 8'h85, 26'h0200000, 1'b0, 0);
    run_op("tie_even",    1'b0, 8'h80, 26'h1000001, 1'b0, 0);
    run_op("tie_up",      1'b0, 8'h80, 26'h1000003, 1'b0, 0);
    run_op("overflow",    1'b0, 8'hFE, 26'h3FFFFFF, 1'b0, 0);
    run_op("underflow",   1'b1, 8'h01, 26'h0000001, 1'b0, 0);
    run_op("zero",        1'b0, 8'h40, 26'h0000000, 1'b0, 0);
    run_op("inf_nan",     1'b1, 8'hFF, 26'h0ABCDEF, 1'b1, 0);
    run_op("max_shift",   1'b0, 8'hC0, 26'h0000002, 1'b1, 0);
    run_op("backpressure", 1'b1, 8'h90, 26'h1234567, 1'b1, 10);

    // Reset while normalizing discards the operand
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'h85; in_mantis = 26'h0200000; in_sticky = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_norm_out_valid", out_valid, 0);
    chk("rst_norm_in_ready", in_ready, 0);
    chk("rst_norm_state", dbg_state, 0);
    chk("rst_norm_result", {out_sign, out_exp, out_frac}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", in_ready, 1);
    chk("rst_release_out_valid", out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("rst_discard_out_valid", out_valid, 0);
    end

    // Randomized operands across the normalization/rounding paths
    for (int i = 0; i < 60; i++) begin
      cls = $urandom_range(0, 4);
      case (cls)
        0:       mt = {1'b1, 25'($urandom)};
        1:       mt = {2'b01, 24'($urandom)};
        2:       mt = {2'b01, 24'($urandom)} >> $urandom_range(1, 24);
        3:       mt = MW'($urandom_range(0, 3));
        default: mt = MW'($urandom);
      endcase
      er = $urandom_range(0, 9);
      case (er)
        0:       ex = 8'hFF;
        1:       ex = E'($urandom_range(0, 2));
        2:       ex = E'($urandom_range(8'hFC, 8'hFE));
        default: ex = E'($urandom_range(1, 8'hFE));
      endcase
      sg = $urandom;
      st = $urandom;
      run_op($sformatf("rand%0d", i), sg, ex, mt, st, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
